// File: rtl/fir_sample_packer.sv
// rtl/fir_sample_packer.sv - packs PSAMPLES narrow multi-channel beats into one wide FIR input word
module fir_sample_packer #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int PSAMPLES   = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]           in_data,
    input  logic                                     flush,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [CHANNELS*DATA_WIDTH*PSAMPLES-1:0]  m_tdata,
    output logic [$clog2(PSAMPLES)-1:0]              lane_cnt
);

    localparam int CW = $clog2(PSAMPLES);
    localparam int WW = CHANNELS * DATA_WIDTH * PSAMPLES;

    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_asm;
    logic          r_asm_full;
    logic [WW-1:0] r_m_tdata;
    logic          r_m_tvalid;

    logic          w_accept;
    logic          w_out_free;
    logic          w_last;
    logic          w_complete;
    logic [WW-1:0] w_asm_lane;
    logic [WW-1:0] w_asm_next;

    assign in_ready   = !r_asm_full && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_out_free = !r_m_tvalid || m_tready;
    assign w_last     = (r_cnt == CW'(PSAMPLES - 1));

    // Flush with an accepted beat closes the word after that beat; unwritten lanes are already zero.
    assign w_complete = !r_asm_full &&
                        ((w_accept && w_last) || (flush && (w_accept || (r_cnt != '0))));

    always_comb begin
        w_asm_lane = r_asm;
        for (int c = 0; c < CHANNELS; c++) begin
            w_asm_lane[(c * PSAMPLES + int'(r_cnt)) * DATA_WIDTH +: DATA_WIDTH] =
                in_data[c * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_asm_next = w_accept ? w_asm_lane : r_asm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_asm_full <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
        end else begin
            if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (r_asm_full) begin
                if (w_out_free) begin
                    r_m_tdata  <= r_asm;
                    r_m_tvalid <= 1'b1;
                    r_asm_full <= 1'b0;
                    r_cnt      <= '0;
                    r_asm      <= '0;
                end
            end else if (w_complete) begin
                if (w_out_free) begin
                    r_m_tdata  <= w_asm_next;
                    r_m_tvalid <= 1'b1;
                    r_cnt      <= '0;
                    r_asm      <= '0;
                end else begin
                    // Park the finished word in asm; cnt holds until the output frees up.
                    r_asm      <= w_asm_next;
                    r_asm_full <= 1'b1;
                end
            end else if (w_accept) begin
                r_asm <= w_asm_lane;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign lane_cnt = r_cnt;

endmodule

// File: tb/tb_fir_sample_packer.sv
// tb/tb_fir_sample_packer.sv - scoreboard bench for fir_sample_packer
module tb_fir_sample_packer;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int PS = 8;
    localparam int WW = CH * DW * PS;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH*DW-1:0] in_data;
    logic            flush;
    logic            m_tvalid;
    logic            m_tready;
    logic [WW-1:0]   m_tdata;
    logic [2:0]      lane_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_words  = 0;
    int vld_cycles = 0;
    int stall_cnt = 0;

    logic [WW-1:0] sb_q[$];
    logic [WW-1:0] mword;
    int            mcnt;
    logic          prev_stall;
    logic [WW-1:0] prev_data;

    fir_sample_packer #(.CHANNELS(CH), .DATA_WIDTH(DW), .PSAMPLES(PS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .lane_cnt (lane_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_push();
        sb_q.push_back(mword);
        mword = '0;
        mcnt  = 0;
    endtask

    task automatic send_beat(input logic [15:0] c0, input logic [15:0] c1, input logic fl);
        logic acc;
        int   waited;
        in_valid = 1'b1;
        in_data  = {c1, c0};
        flush    = fl;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stall_cnt++;
                waited++;
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!acc) begin
            check_val("beat_timeout", 0, 1);
        end else begin
            mword[(0 * PS + mcnt) * DW +: DW] = c0;
            mword[(1 * PS + mcnt) * DW +: DW] = c1;
            mcnt++;
            if (fl || mcnt == PS) model_push();
        end
    endtask

    task automatic send_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (mcnt > 0) model_push();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || m_tvalid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_empty", sb_q.size(), 0);
    endtask

    // Output monitor: compares every handshaked word and the hold-stable rule under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_vld", m_tvalid, 1);
                check_val("hold_data", m_tdata, prev_data);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (m_tvalid) vld_cycles++;
            if (m_tvalid && m_tready) begin
                n_words++;
                if (sb_q.size() == 0) check_val("unexpected_word", m_tdata, 0);
                else check_val("word", m_tdata, sb_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; m_tready = 1'b1;
        mword = '0; mcnt = 0; prev_stall = 1'b0; prev_data = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready_after", in_ready, 1);
        check_val("rst_tvalid", m_tvalid, 0);
        check_val("rst_tdata", m_tdata, 0);
        check_val("rst_lane_cnt", lane_cnt, 0);
        @(posedge clk); #1;

        // Test 1: lane 0 only
        vld_cycles = 0;
        send_beat(16'h7fff, 16'h7fff, 1'b0);
        for (int i = 1; i < 8; i++) send_beat(16'h0, 16'h0, 1'b0);
        @(negedge clk);
        check_val("t1_ch0_lane0", m_tdata[15:0], 16'h7fff);
        check_val("t1_ch1_lane0", m_tdata[143:128], 16'h7fff);
        drain();
        repeat (3) @(negedge clk);
        check_val("t1_vld_cycles", vld_cycles, 1);

        // Test 2: 64 continuous beats, full rate
        @(posedge clk); #1;
        stall_cnt = 0;
        w0 = n_words;
        for (int i = 0; i < 64; i++) send_beat(16'(i), 16'(i + 1000), 1'b0);
        drain();
        check_val("t2_no_stall", stall_cnt, 0);
        check_val("t2_words", n_words - w0, 8);

        // Test 3: backpressure with two words
        @(posedge clk); #1;
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(16'(16'h100 + i), 16'(16'h200 + i), 1'b0);
        @(negedge clk);
        check_val("t3_in_ready_low", in_ready, 0);
        check_val("t3_tvalid", m_tvalid, 1);
        repeat (4) @(negedge clk);
        check_val("t3_still_low", in_ready, 0);
        @(posedge clk); #1;
        m_tready = 1'b1;
        drain();
        check_val("t3_in_ready_back", in_ready, 1);

        // Test 4: three beats then flush
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) send_beat(16'(i), 16'(16'h40 + i), 1'b0);
        @(negedge clk);
        check_val("t4_lane_cnt3", lane_cnt, 3);
        @(posedge clk); #1;
        send_flush();
        drain();
        check_val("t4_lane_cnt0", lane_cnt, 0);

        // Test 5: empty flush, then flush together with beat 5
        @(posedge clk); #1;
        w0 = n_words;
        send_flush();
        repeat (5) @(negedge clk);
        check_val("t5_no_word", n_words - w0, 0);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send_beat(16'(16'h500 + i), 16'(16'h600 + i), 1'b0);
        send_beat(16'h0505, 16'h0605, 1'b1);
        drain();
        check_val("t5_lane_cnt0", lane_cnt, 0);

        // Test 6: reset with pending word and cnt=5
        @(posedge clk); #1;
        m_tready = 1'b0;
        for (int i = 0; i < 13; i++) send_beat(16'(16'h700 + i), 16'(16'h800 + i), 1'b0);
        @(negedge clk);
        check_val("t6_lane_cnt5", lane_cnt, 5);
        check_val("t6_pending", m_tvalid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_in_ready_rst", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        mword = '0;
        mcnt = 0;
        @(negedge clk);
        check_val("t6_tvalid0", m_tvalid, 0);
        check_val("t6_lane_cnt0", lane_cnt, 0);
        check_val("t6_in_ready1", in_ready, 1);
        @(posedge clk); #1;
        m_tready = 1'b1;
        w0 = n_words;
        for (int i = 0; i < 8; i++) send_beat(16'(16'h900 + i), 16'(16'ha00 + i), 1'b0);
        drain();
        check_val("t6_words", n_words - w0, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
